// File: rtl/nios2_mult_sched_pkg.sv
// Shared types and constants for the multiplier-cell sequencer/arbiter.
// Opcode and state encodings, plus a helper for sizing requester ids.
package nios2_mult_sched_pkg;

   typedef enum logic [1:0] {
      MUL    = 2'd0,
      MULXUU = 2'd1,
      MULXSU = 2'd2,
      MULXSS = 2'd3
   } op_t;

   typedef enum logic [2:0] {
      IDLE,
      ISS1,
      CAP1,
      ISS2,
      CAP2,
      RESP
   } state_t;

   localparam int MUL_LAT  = 3;
   localparam int MULX_LAT = 5;

   function automatic int id_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/nios2_mult_sched_if.sv
// Requester-side bus of the scheduler.
// Requests and responses of all requesters are packed side by side.
interface nios2_mult_sched_if #(
   parameter int NUM_REQ = 2
) ();

   logic [NUM_REQ-1:0]    req_valid;
   logic [NUM_REQ-1:0]    req_ready;
   logic [2*NUM_REQ-1:0]  req_op;
   logic [32*NUM_REQ-1:0] req_a;
   logic [32*NUM_REQ-1:0] req_b;
   logic [NUM_REQ-1:0]    rsp_valid;
   logic [NUM_REQ-1:0]    rsp_ready;
   logic [31:0]           rsp_data;

   modport master (
      output req_valid, req_op, req_a, req_b, rsp_ready,
      input  req_ready, rsp_valid, rsp_data
   );

   modport slave (
      input  req_valid, req_op, req_a, req_b, rsp_ready,
      output req_ready, rsp_valid, rsp_data
   );

endinterface

// File: rtl/nios2_mult_rr_arbiter.sv
// Combinational round-robin arbiter: first valid request at or above ptr, wrapping.
// The pointer register lives in the parent.
module nios2_mult_rr_arbiter
   import nios2_mult_sched_pkg::*;
#(
   parameter int NUM_REQ = 2,
   localparam int IDW = id_width(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] req,
   input  logic [IDW-1:0]     ptr,
   input  logic               en,
   output logic [NUM_REQ-1:0] grant,
   output logic [IDW-1:0]     id
);

   logic         found;
   logic [IDW:0] cand;

   always_comb begin
      grant = '0;
      id    = '0;
      found = 1'b0;
      cand  = '0;
      if (en) begin
         for (int i = 0; i < NUM_REQ; i++) begin
            cand = {1'b0, ptr} + (IDW+1)'(i);
            if (cand >= (IDW+1)'(NUM_REQ)) cand = cand - (IDW+1)'(NUM_REQ);
            for (int j = 0; j < NUM_REQ; j++) begin
               if (!found && req[j] && cand == (IDW+1)'(j)) begin
                  found    = 1'b1;
                  grant[j] = 1'b1;
                  id       = IDW'(j);
               end
            end
         end
      end
   end

endmodule

// File: rtl/nios2_mult_sched.sv
// Shares one 3-product 16x16 multiplier cell between requesters.
// MUL takes one pass; MULX* takes a second pass reusing p1 for a_hi*b_hi.
module nios2_mult_sched
   import nios2_mult_sched_pkg::*;
#(
   parameter int NUM_REQ  = 2,
   parameter int RR_RESET = 0,
   localparam int IDW = id_width(NUM_REQ)
) (
   input  logic        clk,
   input  logic        reset_n,
   nios2_mult_sched_if.slave bus,
   output logic [31:0] cell_src1,
   output logic [31:0] cell_src2,
   output logic        cell_en,
   input  logic [31:0] cell_p1,
   input  logic [31:0] cell_p2,
   input  logic [31:0] cell_p3
);

   state_t             state, next_state;
   op_t                op_q, win_op;
   logic [31:0]        a_q, b_q, win_a, win_b, rsp_data_q;
   logic [IDW-1:0]     id_q, rr_ptr, win_id, next_ptr;
   logic [IDW:0]       ptr_inc;
   logic [NUM_REQ-1:0] grant;
   logic               transfer;
   logic [16:0]        carry_hi;
   logic [32:0]        mid;
   logic [48:0]        sum;
   logic [31:0]        hu, corr_a, corr_b, mulx_word;

   nios2_mult_rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
      .req   (bus.req_valid),
      .ptr   (rr_ptr),
      .en    (state == IDLE),
      .grant (grant),
      .id    (win_id)
   );

   assign bus.req_ready = grant;
   assign bus.rsp_data  = rsp_data_q;
   assign transfer      = |grant;

   always_comb begin
      win_op = MUL;
      win_a  = '0;
      win_b  = '0;
      for (int j = 0; j < NUM_REQ; j++) begin
         if (win_id == IDW'(j)) begin
            win_op = op_t'(bus.req_op[2*j +: 2]);
            win_a  = bus.req_a[32*j +: 32];
            win_b  = bus.req_b[32*j +: 32];
         end
      end
      ptr_inc  = {1'b0, win_id} + (IDW+1)'(1);
      next_ptr = (ptr_inc == (IDW+1)'(NUM_REQ)) ? '0 : ptr_inc[IDW-1:0];
   end

   // Partial-product assembly; bits above 48 never matter for the high word.
   always_comb begin
      mid    = {1'b0, cell_p2} + {1'b0, cell_p3};
      sum    = {17'b0, cell_p1} + {mid, 16'b0};
      hu     = cell_p1 + {15'b0, carry_hi};
      corr_a = a_q[31] ? b_q : 32'd0;
      corr_b = b_q[31] ? a_q : 32'd0;
      unique case (op_q)
         MULXSU:  mulx_word = hu - corr_a;
         MULXSS:  mulx_word = hu - corr_a - corr_b;
         default: mulx_word = hu;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset_n) state <= IDLE;
      else          state <= next_state;
   end

   always_comb begin
      next_state    = state;
      cell_en       = 1'b0;
      bus.rsp_valid = '0;
      unique case (state)
         IDLE: if (transfer) next_state = ISS1;
         ISS1: begin
            cell_en    = 1'b1;
            next_state = CAP1;
         end
         CAP1: next_state = (op_q == MUL) ? RESP : ISS2;
         ISS2: begin
            cell_en    = 1'b1;
            next_state = CAP2;
         end
         CAP2: next_state = RESP;
         RESP: begin
            bus.rsp_valid = NUM_REQ'(1) << id_q;
            if (bus.rsp_ready[id_q]) next_state = IDLE;
         end
         default: next_state = IDLE;
      endcase
   end

   // Operands are loaded one state early so they are stable while cell_en is high.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         op_q       <= MUL;
         a_q        <= '0;
         b_q        <= '0;
         id_q       <= '0;
         rr_ptr     <= IDW'(RR_RESET);
         carry_hi   <= '0;
         rsp_data_q <= '0;
         cell_src1  <= '0;
         cell_src2  <= '0;
      end else begin
         unique case (state)
            IDLE: if (transfer) begin
               op_q      <= win_op;
               a_q       <= win_a;
               b_q       <= win_b;
               id_q      <= win_id;
               rr_ptr    <= next_ptr;
               cell_src1 <= win_a;
               cell_src2 <= win_b;
            end
            CAP1: begin
               carry_hi <= sum[48:32];
               if (op_q == MUL) begin
                  rsp_data_q <= sum[31:0];
               end else begin
                  cell_src1 <= {16'b0, a_q[31:16]};
                  cell_src2 <= {16'b0, b_q[31:16]};
               end
            end
            CAP2: rsp_data_q <= mulx_word;
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_nios2_mult_sched.sv
// Self-checking bench for nios2_mult_sched with a behavioural multiplier cell
// and a full-width arithmetic reference model.
module tb_nios2_mult_sched;
   import nios2_mult_sched_pkg::*;

   localparam int NR = 2;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic [31:0] cell_src1, cell_src2;
   logic        cell_en;
   logic [31:0] cell_p1 = '0, cell_p2 = '0, cell_p3 = '0;
   int          total = 0;
   int          bad = 0;

   always #5 clk = ~clk;

   nios2_mult_sched_if #(.NUM_REQ(NR)) bus ();

   nios2_mult_sched #(.NUM_REQ(NR), .RR_RESET(0)) dut (
      .clk       (clk),
      .reset_n   (reset_n),
      .bus       (bus),
      .cell_src1 (cell_src1),
      .cell_src2 (cell_src2),
      .cell_en   (cell_en),
      .cell_p1   (cell_p1),
      .cell_p2   (cell_p2),
      .cell_p3   (cell_p3)
   );

   // Multiplier cell: one registered stage gated by the enable.
   always @(posedge clk) begin
      if (cell_en) begin
         cell_p1 <= {16'b0, cell_src1[15:0]}  * {16'b0, cell_src2[15:0]};
         cell_p2 <= {16'b0, cell_src1[15:0]}  * {16'b0, cell_src2[31:16]};
         cell_p3 <= {16'b0, cell_src1[31:16]} * {16'b0, cell_src2[15:0]};
      end
   end

   initial begin
      #2_000_000;
      $display("[TB] FAIL watchdog: got=timeout expected=finish");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("[TB] FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] refResult(input op_t op, input logic [31:0] a, input logic [31:0] b);
      logic [63:0] ea, eb, p;
      ea = (op == MULXSU || op == MULXSS) ? {{32{a[31]}}, a} : {32'b0, a};
      eb = (op == MULXSS) ? {{32{b[31]}}, b} : {32'b0, b};
      p  = ea * eb;
      return (op == MUL) ? p[31:0] : p[63:32];
   endfunction

   task automatic setReq(input int id, input op_t op, input logic [31:0] a, input logic [31:0] b);
      bus.req_op[2*id +: 2] = op;
      bus.req_a[32*id +: 32] = a;
      bus.req_b[32*id +: 32] = b;
   endtask

   // Called just after a negedge; returns just after the negedge following acceptance.
   task automatic waitAccept(input int id, output bit acc);
      acc = 1'b0;
      for (int c = 0; c < 20 && !acc; c++) begin
         #1;
         if (bus.req_ready[id]) acc = 1'b1;
         @(negedge clk);
      end
   endtask

   task automatic applyStimulus(input int id, input op_t op, input logic [31:0] a,
                                input logic [31:0] b, input int hold);
      logic [31:0]   exp, held;
      logic [NR-1:0] own;
      int            lat, en_cnt, other;
      bit            acc;
      exp   = refResult(op, a, b);
      own   = NR'(1) << id;
      other = 1 - id;
      setReq(id, op, a, b);
      bus.req_valid[id] = 1'b1;
      waitAccept(id, acc);
      bus.req_valid[id] = 1'b0;
      checkOutput("accept", 64'(acc), 64'd1);
      if (!acc) return;
      setReq(id, op_t'($urandom_range(0, 3)), $urandom, $urandom);
      lat = 1;
      en_cnt = 0;
      while (bus.rsp_valid == '0 && lat < 12) begin
         if (cell_en) en_cnt++;
         @(negedge clk);
         lat++;
      end
      checkOutput("latency", 64'(lat), 64'((op == MUL) ? MUL_LAT : MULX_LAT));
      checkOutput("cell_en_cycles", 64'(en_cnt), 64'((op == MUL) ? 1 : 2));
      checkOutput("rsp_valid_target", 64'(bus.rsp_valid), 64'(own));
      checkOutput("rsp_data", 64'(bus.rsp_data), 64'(exp));
      held = bus.rsp_data;
      if (hold > 0) begin
         setReq(other, op_t'($urandom_range(0, 3)), $urandom, $urandom);
         bus.req_valid[other] = 1'b1;
      end
      for (int h = 0; h < hold; h++) begin
         #1;
         checkOutput("hold_no_grant", 64'(bus.req_ready), 64'd0);
         @(negedge clk);
         checkOutput("hold_rsp_valid", 64'(bus.rsp_valid), 64'(own));
         checkOutput("hold_rsp_data", 64'(bus.rsp_data), 64'(held));
      end
      bus.rsp_ready[id] = 1'b1;
      @(negedge clk);
      bus.rsp_ready[id] = 1'b0;
      checkOutput("rsp_released", 64'(bus.rsp_valid), 64'd0);
      if (hold > 0) begin
         checkOutput("next_grant", 64'(bus.req_ready), 64'(NR'(1) << other));
         bus.req_valid[other] = 1'b0;
      end
   endtask

   initial begin
      int          gcount, drain;
      int          gid_q[$];
      logic [31:0] exp_q[$];
      logic [31:0] pick [4];
      bit          acc;
      op_t         rop;

      bus.req_valid = '0;
      bus.req_op    = '0;
      bus.req_a     = '0;
      bus.req_b     = '0;
      bus.rsp_ready = '0;
      repeat (3) @(negedge clk);
      checkOutput("reset_req_ready", 64'(bus.req_ready), 64'd0);
      checkOutput("reset_rsp_valid", 64'(bus.rsp_valid), 64'd0);
      checkOutput("reset_rsp_data", 64'(bus.rsp_data), 64'd0);
      checkOutput("reset_cell_en", 64'(cell_en), 64'd0);
      checkOutput("reset_cell_src1", 64'(cell_src1), 64'd0);
      checkOutput("reset_cell_src2", 64'(cell_src2), 64'd0);
      reset_n = 1'b1;
      @(negedge clk);

      $display("[TB] round-robin with two continuous requesters");
      for (int r = 0; r < NR; r++) setReq(r, op_t'($urandom_range(0, 3)), $urandom, $urandom);
      bus.rsp_ready = '1;
      bus.req_valid = '1;
      gcount = 0;
      drain  = 0;
      for (int c = 0; c < 400 && drain < 10; c++) begin
         if (bus.rsp_valid != '0) begin
            if (exp_q.size() > 0) begin
               checkOutput("rr_rsp_target", 64'(bus.rsp_valid), 64'(NR'(1) << gid_q.pop_front()));
               checkOutput("rr_rsp_data", 64'(bus.rsp_data), 64'(exp_q.pop_front()));
            end else begin
               checkOutput("rr_rsp_unexpected", 64'(bus.rsp_valid), 64'd0);
            end
         end
         if (gcount >= 8) begin
            bus.req_valid = '0;
            drain++;
         end
         #1;
         checkOutput("rr_ready_onehot", 64'($countones(bus.req_ready) <= 1), 64'd1);
         for (int r = 0; r < NR; r++) begin
            if (bus.req_ready[r]) begin
               checkOutput("rr_grant_order", 64'(r), 64'(gcount % 2));
               gid_q.push_back(r);
               exp_q.push_back(refResult(op_t'(bus.req_op[2*r +: 2]),
                                         bus.req_a[32*r +: 32], bus.req_b[32*r +: 32]));
               gcount++;
            end else begin
               setReq(r, op_t'($urandom_range(0, 3)), $urandom, $urandom);
            end
         end
         @(negedge clk);
      end
      bus.req_valid = '0;
      bus.rsp_ready = '0;
      checkOutput("rr_grant_total", 64'(gcount), 64'd8);
      checkOutput("rr_drained", 64'(exp_q.size()), 64'd0);

      $display("[TB] directed operations");
      applyStimulus(0, MUL,    32'h00012345, 32'h00010000, 0);
      applyStimulus(1, MULXUU, 32'hFFFFFFFF, 32'hFFFFFFFF, 0);
      applyStimulus(0, MUL,    32'hFFFFFFFF, 32'hFFFFFFFF, 0);
      applyStimulus(1, MULXSS, 32'hFFFFFFFF, 32'hFFFFFFFF, 0);
      applyStimulus(0, MULXSU, 32'hFFFFFFFF, 32'hFFFFFFFF, 0);
      applyStimulus(1, MULXSS, 32'h80000000, 32'h7FFFFFFF, 0);
      applyStimulus(0, MULXSU, 32'h87654321, 32'h12345678, 4);

      $display("[TB] randomized operations");
      pick[0] = 32'h00000000;
      pick[1] = 32'hFFFFFFFF;
      pick[2] = 32'h80000000;
      pick[3] = 32'h7FFFFFFF;
      for (int n = 0; n < 30; n++) begin
         logic [31:0] ra, rb;
         rop = op_t'($urandom_range(0, 3));
         ra  = ($urandom_range(0, 3) == 0) ? pick[$urandom_range(0, 3)] : $urandom;
         rb  = ($urandom_range(0, 3) == 0) ? pick[$urandom_range(0, 3)] : $urandom;
         applyStimulus($urandom_range(0, 1), rop, ra, rb, $urandom_range(0, 2));
      end

      $display("[TB] reset during CAP1 of MULXUU");
      setReq(0, MULXUU, 32'hFFFFFFFF, 32'hFFFFFFFF);
      bus.req_valid[0] = 1'b1;
      waitAccept(0, acc);
      bus.req_valid[0] = 1'b0;
      checkOutput("abort_accept", 64'(acc), 64'd1);
      @(negedge clk);
      reset_n = 1'b0;
      @(negedge clk);
      checkOutput("abort_rsp_valid", 64'(bus.rsp_valid), 64'd0);
      checkOutput("abort_rsp_data", 64'(bus.rsp_data), 64'd0);
      checkOutput("abort_cell_en", 64'(cell_en), 64'd0);
      checkOutput("abort_cell_src1", 64'(cell_src1), 64'd0);
      checkOutput("abort_cell_src2", 64'(cell_src2), 64'd0);
      checkOutput("abort_req_ready", 64'(bus.req_ready), 64'd0);
      @(negedge clk);
      reset_n = 1'b1;
      bus.req_valid = '1;
      #1;
      checkOutput("abort_idle_ptr", 64'(bus.req_ready), 64'd1);
      bus.req_valid = '0;
      for (int c = 0; c < 6; c++) begin
         @(negedge clk);
         checkOutput("abort_no_rsp", 64'(bus.rsp_valid), 64'd0);
      end
      applyStimulus(0, MUL, 32'h00012345, 32'h00010000, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/nios2_mult_sched.md
Name: nios2_mult_sched

Overview:
- Sequencer and arbiter in front of the 3-product 16x16 multiplier cell (p1=a_lo*b_lo, p2=a_lo*b_hi, p3=a_hi*b_lo; one registered stage gated by the enable).
- Shares the cell between NUM_REQ requesters using round-robin arbitration.
- Drives the cell's operands and enable, captures the partial products and assembles the 32-bit result.
- MUL needs one pass. MULX* (high word, any signedness) needs a second pass that reuses p1 for a_hi*b_hi.

Parameters:
- NUM_REQ, 2, number of requesters (1..4).
- RR_RESET, 0, index of the requester holding highest priority after reset.

Ports:
- clk  in  1  clock.
- reset_n  in  1  synchronous, active-low reset, sampled on the rising edge of clk.
- req_valid  in  NUM_REQ  per-requester request valid.
- req_ready  out  NUM_REQ  per-requester accept, one-hot or zero.
- req_op  in  2*NUM_REQ  opcode per requester: 0 MUL, 1 MULXUU, 2 MULXSU (a signed, b unsigned), 3 MULXSS.
- req_a  in  32*NUM_REQ  operand A per requester.
- req_b  in  32*NUM_REQ  operand B per requester.
- rsp_valid  out  NUM_REQ  result valid, returned to the requester that issued the request.
- rsp_ready  in  NUM_REQ  result accept.
- rsp_data  out  32  result word, valid while any rsp_valid bit is set.
- cell_src1  out  32  to multiplier cell operand 1.
- cell_src2  out  32  to multiplier cell operand 2.
- cell_en  out  1  to multiplier cell enable.
- cell_p1  in  32  partial product from cell.
- cell_p2  in  32  partial product from cell.
- cell_p3  in  32  partial product from cell.

Behaviour:
- Reset values: req_ready=0, rsp_valid=0, rsp_data=0, cell_en=0, cell_src1=0, cell_src2=0, state=IDLE, rr pointer=RR_RESET. Reset mid-operation abandons the operation and produces no response.
- FSM states: IDLE, ISS1, CAP1, ISS2, CAP2, RESP.
- IDLE: the arbiter picks the first requester with req_valid set, searching from the rr pointer upward and wrapping. The winner's req_ready=1 combinationally in the same cycle; a transfer occurs on valid&ready. On transfer: latch op, a, b and the requester id; set the rr pointer to id+1 mod NUM_REQ; go to ISS1. req_ready=0 in every other state.
- ISS1: cell_src1=a, cell_src2=b, cell_en=1; go to CAP1.
- CAP1: cell_en=0; the cell outputs are valid this cycle. Compute:
  - mid = p2+p3, 33 bits.
  - s = {32'b0,p1} + (mid<<16), 64 bits.
  - Register lo=s[31:0] and carry_hi=s[48:32].
  - If op==MUL, set rsp_data=lo and go to RESP; otherwise go to ISS2.
- ISS2: cell_src1={16'b0,a[31:16]}, cell_src2={16'b0,b[31:16]}, cell_en=1; go to CAP2.
- CAP2: hu = cell_p1 + carry_hi, mod 2^32.
  - MULXUU: rsp_data = hu.
  - MULXSU: rsp_data = hu - (a[31]?b:0).
  - MULXSS: rsp_data = hu - (a[31]?b:0) - (b[31]?a:0).
  - All arithmetic mod 2^32. Go to RESP.
- RESP: rsp_valid[id]=1; rsp_data is held stable until rsp_ready[id]. On the handshake, return to IDLE. The next request can be accepted no earlier than the following cycle.
- Latency from the acceptance edge to rsp_valid high: 3 cycles for MUL, 5 cycles for MULX*. Throughput is one operation in flight.
- cell_en is high only in ISS1 and ISS2, so the cell outputs hold stable between passes. cell_src1/cell_src2 are registered and hold their last value outside the issue states.
- Requester changes to req_a/req_b/req_op after acceptance have no effect.
- When a lone requester keeps req_valid asserted, it is re-granted each time the FSM returns to IDLE.

Decomposition:
- Package nios2_mult_sched_pkg holds:
  - op_t encoding: MUL=0, MULXUU=1, MULXSU=2, MULXSS=3.
  - state_t enum.
  - Latency constants MUL_LAT=3 and MULX_LAT=5.
- Sub-module nios2_mult_rr_arbiter, parameterised by NUM_REQ. Inputs: request vector, pointer, enable. Outputs: one-hot grant and encoded id. Purely combinational; the pointer register stays in the parent.

Test Plan:
- MUL, a=0x00012345, b=0x00010000 -> rsp_data=0x23450000, 3 cycles after accept; cell_en high for exactly 1 cycle.
- MULXUU, a=b=0xFFFFFFFF -> 0xFFFFFFFE, 5 cycles after accept. MUL with the same operands -> 0x00000001.
- MULXSS, a=b=0xFFFFFFFF -> 0x00000000. MULXSU with the same operands -> 0xFFFFFFFF. MULXSS, a=0x80000000, b=0x7FFFFFFF -> 0xC0000000.
- Requesters 0 and 1 both valid continuously after reset -> grants in the order 0,1,0,1; each rsp_valid reaches only the issuing requester; req_ready is never high for both.
- rsp_ready held low for 4 cycles in RESP -> rsp_valid and rsp_data stay stable, no new grant; ready pulses -> IDLE, next grant on the following cycle.
- reset_n low during CAP1 of a MULXUU -> next edge: all outputs 0, state IDLE, no response; a new MUL after release completes normally.
